// File: rtl/win_fetch_ctrl.sv
// win_fetch_ctrl: raster-scan fetch of 7x7 windows from frame memory into a 2-entry valid/ready FIFO.
// Optional feature macro WIN_SUM_EN adds win_sum, the pixel sum of the FIFO head window.
module win_fetch_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int WIN     = 7,
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 19
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       ren,
  output logic [A_WIDTH-1:0]         raddr,
  input  logic [WIN*WIN*D_WIDTH-1:0] rdata,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [WIN*WIN*D_WIDTH-1:0] win_data,
  output logic [A_WIDTH-1:0]         win_caddr,
  output logic                       win_last
`ifdef WIN_SUM_EN
  ,
  output logic [13:0]                win_sum
`endif
);
  localparam int DW = WIN * WIN * D_WIDTH;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - WIN);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - WIN);
  localparam logic [A_WIDTH-1:0] C_OFF = A_WIDTH'((WIN / 2) * IMG_W + WIN / 2);
  localparam logic [A_WIDTH-1:0] ROW_STEP = A_WIDTH'(WIN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [A_WIDTH-1:0] nxt_addr, last_addr;
  logic at_end, push, pop;
  logic cap, cap_last;
  logic [A_WIDTH-1:0] cap_caddr;
  logic [DW-1:0] f_data [2];
  logic [A_WIDTH-1:0] f_caddr [2];
  logic [1:0] f_last;
  logic [1:0] count;
  logic wp, rp;

  assign at_end    = (x == X_MAX) && (y == Y_MAX);
  assign win_valid = count != 2'd0;
  assign pop       = win_valid && win_ready;
  assign push      = cap;
  assign win_data  = f_data[rp];
  assign win_caddr = f_caddr[rp];
  assign win_last  = win_valid && f_last[rp];

  // Read issue gating, address mux and next-state; a same-cycle pop frees a slot
  always_comb begin
    ren       = (state == RUN) && (({1'b0, count} + {2'b0, cap} - {2'b0, pop}) < 3'd2);
    raddr     = ren ? nxt_addr : last_addr;
    busy      = (state == RUN) || (state == DRAIN);
    done      = state == DONE;
    state_nxt = (state == IDLE && start)           ? RUN   :
                (state == RUN && ren && at_end)     ? DRAIN :
                (state == DRAIN && pop && win_last) ? DONE  :
                (state == DONE)                     ? IDLE  : state;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Scan position: restart on start, step +1 per read, jump to next row start at row end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      nxt_addr  <= '0;
      last_addr <= '0;
    end else if (state == IDLE && start) begin
      x        <= '0;
      y        <= '0;
      nxt_addr <= '0;
    end else if (ren) begin
      last_addr <= nxt_addr;
      if (x == X_MAX) begin
        x        <= '0;
        y        <= y + 1'b1;
        nxt_addr <= nxt_addr + ROW_STEP;
      end else begin
        x        <= x + 1'b1;
        nxt_addr <= nxt_addr + 1'b1;
      end
    end
  end

  // Tag of the read in flight, aligned with rdata one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap       <= 1'b0;
      cap_caddr <= '0;
      cap_last  <= 1'b0;
    end else begin
      cap       <= ren;
      cap_caddr <= raddr + C_OFF;
      cap_last  <= ren && at_end;
    end
  end

  // Two-entry FIFO; issue gating guarantees a free slot whenever a capture arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_data[0]  <= '0;
      f_data[1]  <= '0;
      f_caddr[0] <= '0;
      f_caddr[1] <= '0;
      f_last     <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      count      <= '0;
    end else begin
      if (push) begin
        f_data[wp]  <= rdata;
        f_caddr[wp] <= cap_caddr;
        f_last[wp]  <= cap_last;
        wp          <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef WIN_SUM_EN
  logic [13:0] sum_in;
  logic [13:0] f_sum [2];

  assign win_sum = f_sum[rp];

  // Sum of all pixels of the window arriving on rdata
  always_comb begin
    sum_in = '0;
    for (int i = 0; i < WIN * WIN; i++) sum_in = sum_in + 14'(rdata[i*D_WIDTH +: D_WIDTH]);
  end

  // Sums stored alongside their FIFO entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_sum[0] <= '0;
      f_sum[1] <= '0;
    end else if (push) begin
      f_sum[wp] <= sum_in;
    end
  end
`endif
endmodule

// File: tb/tb_win_fetch_ctrl.sv
// tb_win_fetch_ctrl: scoreboard bench for win_fetch_ctrl (full-size instance plus a 16x12 instance for whole frames).
module tb_win_fetch_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a_start, a_ready, b_start, b_ready;
  logic a_busy, a_done, a_ren, a_valid, a_last;
  logic b_busy, b_done, b_ren, b_valid, b_last;
  logic [18:0] a_raddr, a_caddr, b_raddr, b_caddr;
  logic [391:0] a_rdata, a_data, b_rdata, b_data;
`ifdef WIN_SUM_EN
  logic [13:0] a_sum, b_sum;
`endif
  int total = 0, bad = 0, fill = 0;
  int a_hs = 0, b_hs = 0, b_lasts = 0;
  int qa[$], qra[$], qb[$];
  logic [18:0] a_last_ra = '0;

  win_fetch_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .ren(a_ren), .raddr(a_raddr), .rdata(a_rdata), .win_valid(a_valid),
    .win_ready(a_ready), .win_data(a_data), .win_caddr(a_caddr), .win_last(a_last)
`ifdef WIN_SUM_EN
    , .win_sum(a_sum)
`endif
  );

  win_fetch_ctrl #(.IMG_W(16), .IMG_H(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .ren(b_ren), .raddr(b_raddr), .rdata(b_rdata), .win_valid(b_valid),
    .win_ready(b_ready), .win_data(b_data), .win_caddr(b_caddr), .win_last(b_last)
`ifdef WIN_SUM_EN
    , .win_sum(b_sum)
`endif
  );

  function automatic logic [391:0] pat(input logic [18:0] a);
    return {12'hABC, {19{{1'b1, a}}}};
  endfunction

  function automatic logic [391:0] word(input logic [18:0] a);
    return fill == 1 ? {392{1'b1}} : fill == 2 ? {49{8'h01}} : pat(a);
  endfunction

`ifdef WIN_SUM_EN
  function automatic int bsum(input logic [391:0] w);
    int s = 0;
    for (int i = 0; i < 49; i++) s += int'(w[i*8 +: 8]);
    return s;
  endfunction
`endif

  function automatic int tl_a(input int i);
    return (i / 634) * 640 + i % 634;
  endfunction

  function automatic int tl_b(input int i);
    return (i / 10) * 16 + i % 10;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chkw(input string n, input logic [391:0] act, input logic [391:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Frame memory models with registered read
  always @(posedge clk) if (a_ren) a_rdata <= word(a_raddr);
  always @(posedge clk) if (b_ren) b_rdata <= word(b_raddr);

  // Monitor for the full-size instance: read addresses and handshakes
  always @(negedge clk) begin : mon_a
    int tla;
    if (rst_n && a_ren) begin
      if (qra.size() > 0) chk("a_raddr", 64'(a_raddr), 64'(qra.pop_front()));
      a_last_ra = a_raddr;
    end
    if (rst_n && a_valid && a_ready) begin
      a_hs++;
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra: caddr %0d arrived with none expected", a_caddr);
      end else begin
        tla = qa.pop_front();
        chk("a_caddr", 64'(a_caddr), 64'(tla + 1923));
        chkw("a_data", a_data, word(19'(tla)));
        chk("a_last", 64'(a_last), 64'(tla == 303353));
`ifdef WIN_SUM_EN
        chk("a_sum", 64'(a_sum), 64'(bsum(word(19'(tla)))));
`endif
      end
    end
  end

  // Monitor for the small instance
  always @(negedge clk) begin : mon_b
    int tlb;
    if (rst_n && b_valid && b_ready) begin
      b_hs++;
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra: caddr %0d arrived with none expected", b_caddr);
      end else begin
        tlb = qb.pop_front();
        chk("b_caddr", 64'(b_caddr), 64'(tlb + 51));
        chkw("b_data", b_data, word(19'(tlb)));
        chk("b_last", 64'(b_last), 64'(tlb == 89));
`ifdef WIN_SUM_EN
        chk("b_sum", 64'(b_sum), 64'(bsum(word(19'(tlb)))));
`endif
        if (b_last) b_lasts++;
      end
    end
  end

  task automatic wait_a(input int target);
    int c = 0;
    while (a_hs < target && c < 5000) begin
      @(posedge clk);
      c++;
    end
    chk("a_reach", 64'(a_hs >= target), 64'd1);
  endtask

  task automatic run_b();
    int base_l = b_lasts;
    int base_h = b_hs;
    int c = 0;
    for (int i = 0; i < 60; i++) qb.push_back(tl_b(i));
    b_ready = 1'b1;
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    chk("b_busy_on", 64'(b_busy), 64'd1);
    chk("b_first_raddr", 64'(b_raddr), 64'd0);
    while (b_lasts == base_l && c < 2000) begin
      b_ready = (c % 3) != 2;
      @(posedge clk);
      #1;
      c++;
    end
    chk("b_last_seen", 64'(b_lasts - base_l), 64'd1);
    chk("b_count", 64'(b_hs - base_h), 64'd60);
    chk("b_q_empty", 64'(qb.size()), 64'd0);
    chk("b_done_pulse", 64'(b_done), 64'd1);
    chk("b_busy_off", 64'(b_busy), 64'd0);
    @(posedge clk);
    #1;
    chk("b_done_end", 64'(b_done), 64'd0);
    chk("b_idle_busy", 64'(b_busy), 64'd0);
  endtask

  initial begin : stim
    logic [391:0] snap_d;
    logic [18:0] snap_c;
    int rens, base;
    rst_n = 1'b0;
    a_start = 1'b0;
    a_ready = 1'b0;
    b_start = 1'b0;
    b_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({a_busy, a_done, a_ren, a_valid, a_last}), 64'd0);
    chk("rst_raddr", 64'(a_raddr), 64'd0);
    chk("rst_caddr", 64'(a_caddr), 64'd0);
    chkw("rst_data", a_data, '0);
    chk("rst_b_ctrl", 64'({b_busy, b_done, b_ren, b_valid, b_last}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      qa.push_back(tl_a(i));
      qra.push_back(tl_a(i));
    end
    @(posedge clk);
    #1;
    a_ready = 1'b1;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    chk("lat_ren", 64'(a_ren), 64'd1);
    chk("lat_raddr", 64'(a_raddr), 64'd0);
    chk("lat_busy", 64'(a_busy), 64'd1);
    chk("lat_valid_n1", 64'(a_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_n2", 64'(a_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_n3", 64'(a_valid), 64'd1);
    chk("lat_caddr", 64'(a_caddr), 64'd1923);
    wait_a(700);
    #1 a_ready = 1'b0;
    @(negedge clk);
    snap_d = a_data;
    snap_c = a_caddr;
    rens = int'(a_ren);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chkw("stall_data", a_data, snap_d);
      chk("stall_caddr", 64'(a_caddr), 64'(snap_c));
      chk("stall_valid", 64'(a_valid), 64'd1);
      rens += int'(a_ren);
    end
    chk("stall_ren_cnt", 64'(rens <= 2), 64'd1);
    chk("stall_ren_off", 64'(a_ren), 64'd0);
    chk("stall_raddr_hold", 64'(a_raddr), 64'(a_last_ra));
    @(posedge clk);
    #1 a_ready = 1'b1;
    wait_a(1000);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 64'({a_busy, a_done, a_ren, a_valid, a_last}), 64'd0);
    chk("abort_raddr", 64'(a_raddr), 64'd0);
    chk("abort_caddr", 64'(a_caddr), 64'd0);
    chkw("abort_data", a_data, '0);
    qa.delete();
    qra.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      qa.push_back(tl_a(i));
      qra.push_back(tl_a(i));
    end
    base = a_hs;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    chk("restart_ren", 64'(a_ren), 64'd1);
    chk("restart_raddr", 64'(a_raddr), 64'd0);
    chk("restart_done", 64'(a_done), 64'd0);
    wait_a(base + 50);
    #1 a_ready = 1'b0;
    run_b();
`ifdef WIN_SUM_EN
    fill = 1;
    run_b();
    chk("sum_ff_ref", 64'(bsum(word(19'd0))), 64'd12495);
    fill = 2;
    run_b();
    chk("sum_01_ref", 64'(bsum(word(19'd0))), 64'd49);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "timeout");
  end
endmodule
